// File: rtl/vz_load_ctrl.sv
// VZ image loader: stalls the Z80, parses the 24-byte header and streams payload into main RAM.
// Optional VZ_PTR_PATCH_EN adds BASIC end-pointer / USR-vector patch writes after the payload.
module vz_load_ctrl #(
    parameter logic [7:0]  VZ_INDEX   = 8'd1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned HDR_LEN    = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        cpu_hold,
    input  logic        cpu_holdack,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] HDR_LEN16  = 16'(HDR_LEN);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [31:0] MAGIC_VZF0 = 32'h565A_4630;
    localparam logic [31:0] MAGIC_ALT  = 32'h2020_0000;

`ifdef VZ_PTR_PATCH_EN
    typedef enum logic [2:0] {IDLE, HOLD, DRAIN, PATCH, RELEASE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HOLD, DRAIN, RELEASE} state_t;
`endif

    state_t          state;
    logic            dl_q;
    logic [7:0]      magic0, magic1, magic2;
    logic [15:0]     start_addr;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [23:0]     fifo_mem [FIFO_DEPTH];

`ifdef VZ_PTR_PATCH_EN
    logic [7:0]      vz_type;
    logic [15:0]     end_off;
    logic            patch_idx;
    logic            patch_skip;
    logic [15:0]     patch_addr;
    logic [7:0]      patch_data;
    logic [15:0]     end_addr;
`endif

    logic            start_ok;
    logic            in_load;
    logic            hdr_wr;
    logic            pay_wr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            overflow;
    logic            magic_bad;
    logic [15:0]     pay_off;
    logic [23:0]     pop_entry;

    always_comb begin
        start_ok   = dn_download && !dl_q && (dn_index == VZ_INDEX);
        in_load    = (state == HOLD);
        hdr_wr     = in_load && dn_wr && (dn_addr < HDR_LEN16);
        pay_wr     = in_load && dn_wr && (dn_addr >= HDR_LEN16);
        pay_off    = dn_addr - HDR_LEN16;
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_C);
        // Payload after a bad magic is discarded, so it can neither fill nor overflow the FIFO.
        push       = pay_wr && !err[0] && !fifo_full;
        overflow   = pay_wr && !err[0] && fifo_full;
        pop        = (state == HOLD || state == DRAIN) && cpu_holdack && !fifo_empty;
        pop_entry  = fifo_mem[rd_ptr];
        magic_bad  = ({magic0, magic1, magic2, dn_data} != MAGIC_VZF0) &&
                     ({magic0, magic1, magic2, dn_data} != MAGIC_ALT);
    end

`ifdef VZ_PTR_PATCH_EN
    always_comb begin
        end_addr   = start_addr + end_off;
        patch_skip = err[0] || !((vz_type == 8'hF0) || (vz_type == 8'hF1));
        patch_addr = 16'h0000;
        patch_data = 8'h00;
        if (vz_type == 8'hF0) begin
            patch_addr = patch_idx ? 16'h78FA : 16'h78F9;
            patch_data = patch_idx ? end_addr[15:8] : end_addr[7:0];
        end else begin
            patch_addr = patch_idx ? 16'h788F : 16'h788E;
            patch_data = patch_idx ? start_addr[15:8] : start_addr[7:0];
        end
    end
`endif

    // Storage carries no reset; flushing is done by clearing the pointers.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pay_off, dn_data};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            magic0     <= 8'h00;
            magic1     <= 8'h00;
            magic2     <= 8'h00;
            start_addr <= 16'h0000;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err        <= 2'b00;
            cpu_hold   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= 16'h0000;
            ram_din    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef VZ_PTR_PATCH_EN
            vz_type    <= 8'h00;
            end_off    <= 16'h0000;
            patch_idx  <= 1'b0;
`endif
        end else begin
            dl_q   <= dn_download;
            ram_we <= 1'b0;
            done   <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
`ifdef VZ_PTR_PATCH_EN
                end_off <= pay_off + 16'd1;
`endif
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                ram_we   <= 1'b1;
                ram_addr <= start_addr + pop_entry[23:8];
                ram_din  <= pop_entry[7:0];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
            if (overflow) begin
                err[1] <= 1'b1;
            end

            if (hdr_wr) begin
                case (dn_addr)
                    16'd0:  magic0 <= dn_data;
                    16'd1:  magic1 <= dn_data;
                    16'd2:  magic2 <= dn_data;
                    16'd3:  if (magic_bad) err[0] <= 1'b1;
`ifdef VZ_PTR_PATCH_EN
                    16'd21: vz_type <= dn_data;
`endif
                    16'd22: start_addr[7:0]  <= dn_data;
                    16'd23: start_addr[15:8] <= dn_data;
                    default: ;
                endcase
            end

            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= HOLD;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        err        <= 2'b00;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        count      <= '0;
                        magic0     <= 8'h00;
                        magic1     <= 8'h00;
                        magic2     <= 8'h00;
                        start_addr <= 16'h0000;
`ifdef VZ_PTR_PATCH_EN
                        vz_type    <= 8'h00;
                        end_off    <= 16'h0000;
`endif
                    end
                end
                HOLD: begin
                    if (!dn_download) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
`ifdef VZ_PTR_PATCH_EN
                        state     <= PATCH;
                        patch_idx <= 1'b0;
`else
                        state     <= RELEASE;
`endif
                    end
                end
`ifdef VZ_PTR_PATCH_EN
                PATCH: begin
                    if (patch_skip) begin
                        state <= RELEASE;
                    end else if (cpu_holdack) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= patch_addr;
                        ram_din   <= patch_data;
                        patch_idx <= 1'b1;
                        if (patch_idx) begin
                            state <= RELEASE;
                        end
                    end
                end
`endif
                RELEASE: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    done     <= (err == 2'b00);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
